// File: rtl/inst_loader.sv
// Instruction memory with a streaming program-load port.
// The CPU fetches combinationally and reads zero while a load is in progress.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | after reset; no load has completed since
//  S_LOAD | accepting program words into ascending addresses from 0
//  S_DONE | most recent load finished (or was an empty load)
module inst_loader #(
    parameter int IW = 10,
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_start,
    input  logic [IW:0]   i_load_count,
    input  logic          i_wr_valid,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    input  logic [IW-1:0] i_inst_address,
    output logic [DW-1:0] o_inst_out,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [IW:0] DEPTH = {1'b1, {IW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW:0]   r_count;
    logic [IW:0]   w_count_nxt;
    logic [IW:0]   r_target;
    logic [IW:0]   w_target_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_wr_en;

    logic [DW-1:0] r_mem [2**IW];

    // A word is taken only in LOAD and never while reset is applied.
    assign w_wr_en = (r_state == S_LOAD) && i_wr_valid && !i_reset;

    // State and load bookkeeping registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_count  <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state logic: start/reject decisions and word acceptance.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_load_start) begin
                    if (i_load_count > DEPTH) begin
                        // Rejected: state is kept, only the flags change.
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b0;
                    end else if (i_load_count == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt  = S_LOAD;
                        w_ptr_nxt    = '0;
                        w_count_nxt  = '0;
                        w_target_nxt = i_load_count;
                        w_done_nxt   = 1'b0;
                        w_err_nxt    = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                if (w_wr_en) begin
                    // Pointer is IW bits wide so a full-depth load wraps to 0.
                    w_ptr_nxt   = r_ptr + 1'b1;
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == r_target - 1'b1) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Program memory; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    // Fetch path: the stalled CPU sees zeros while a load is running.
    always_comb begin
        o_busy     = (r_state == S_LOAD);
        o_wr_ready = (r_state == S_LOAD);
        o_done     = r_done;
        o_err      = r_err;
        o_inst_out = o_busy ? '0 : r_mem[i_inst_address];
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a transaction-level reference model
// checked on every falling edge.
module tb_inst_loader;

    localparam int IW    = 10;
    localparam int DW    = 9;
    localparam int DEPTH = 1 << IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [IW:0]   load_count;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [IW-1:0] inst_address;
    logic [DW-1:0] inst_out;
    logic          busy;
    logic          done;
    logic          err;

    int n_pass  = 0;
    int n_total = 0;

    inst_loader #(.IW(IW), .DW(DW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_load_start   (load_start),
        .i_load_count   (load_count),
        .i_wr_valid     (wr_valid),
        .i_wr_data      (wr_data),
        .o_wr_ready     (wr_ready),
        .i_inst_address (inst_address),
        .o_inst_out     (inst_out),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    // Reference model: words still owed, next address, flags, shadow memory.
    bit            m_loading = 1'b0;
    int            m_left    = 0;
    int            m_addr    = 0;
    bit            m_done    = 1'b0;
    bit            m_err     = 1'b0;
    logic [DW-1:0] m_mem     [DEPTH];
    bit            m_known   [DEPTH];
    int            m_writes  = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_loading = 1'b0;
            m_left    = 0;
            m_addr    = 0;
            m_done    = 1'b0;
            m_err     = 1'b0;
        end else if (m_loading) begin
            if (wr_valid) begin
                m_mem[m_addr]   = wr_data;
                m_known[m_addr] = 1'b1;
                m_writes++;
                m_addr = (m_addr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end else if (load_start) begin
            if (int'(load_count) > DEPTH) begin
                m_err  = 1'b1;
                m_done = 1'b0;
            end else if (load_count == 0) begin
                m_done = 1'b1;
                m_err  = 1'b0;
            end else begin
                m_loading = 1'b1;
                m_left    = int'(load_count);
                m_addr    = 0;
                m_done    = 1'b0;
                m_err     = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 32'(busy), 32'(m_loading));
            check("wr_ready", 32'(wr_ready), 32'(m_loading));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            if (m_loading)
                check("inst_out_stall", 32'(inst_out), 32'd0);
            else if (m_known[inst_address])
                check("inst_out", 32'(inst_out), 32'(m_mem[inst_address]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int cnt);
        load_start = 1'b1;
        load_count = (IW+1)'(cnt);
        tick();
        load_start = 1'b0;
    endtask

    task automatic read_at(input string name, input int addr, input logic [DW-1:0] exp);
        inst_address = IW'(addr);
        #1;
        check(name, 32'(inst_out), 32'(exp));
    endtask

    localparam bit PAT [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int ready_cycles;
        int idx;
        int wr_before;
        logic [DW-1:0] bp_words [4];
        bp_words = '{9'h101, 9'h102, 9'h103, 9'h104};

        reset        = 1'b1;
        load_start   = 1'b0;
        load_count   = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        inst_address = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd0);

        // Basic three-word load with WrValid held high.
        start(3);
        inst_address = 10'd1;
        ready_cycles = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = (i == 0) ? 9'h0E0 : (i == 1) ? 9'h0B0 : 9'h091;
            if (wr_ready) ready_cycles++;
            check("stall_zero", 32'(inst_out), 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        check("basic_ready_cycles", 32'(ready_cycles), 32'd3);
        check("basic_done", 32'(done), 32'd1);
        check("basic_ready_off", 32'(wr_ready), 32'd0);
        read_at("basic_rd0", 0, 9'h0E0);
        read_at("basic_rd1", 1, 9'h0B0);
        read_at("basic_rd2", 2, 9'h091);

        // Backpressure with gaps; producer holds data until accepted.
        start(4);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            wr_valid = PAT[c];
            wr_data  = bp_words[idx < 4 ? idx : 3];
            tick();
            if (PAT[c]) idx++;
        end
        wr_valid = 1'b0;
        check("bp_done", 32'(done), 32'd1);
        wr_before = m_writes;
        wr_valid = 1'b1;
        wr_data  = 9'h1FF;
        tick();
        tick();
        wr_valid = 1'b0;
        check("bp_no_extra_writes", 32'(m_writes - wr_before), 32'd0);
        read_at("bp_rd0", 0, 9'h101);
        read_at("bp_rd1", 1, 9'h102);
        read_at("bp_rd2", 2, 9'h103);
        read_at("bp_rd3", 3, 9'h104);

        // Rejection from IDLE, then an empty load.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start(DEPTH + 1);
        check("rej_err", 32'(err), 32'd1);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_done", 32'(done), 32'd0);
        read_at("rej_rd0", 0, 9'h101);
        start(0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_err", 32'(err), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        read_at("empty_rd3", 3, 9'h104);

        // LoadStart during LOAD is ignored.
        start(2);
        load_start = 1'b1;
        load_count = '0;
        wr_valid   = 1'b1;
        wr_data    = 9'h055;
        tick();
        load_start = 1'b0;
        check("ign_start_busy", 32'(busy), 32'd1);
        wr_data = 9'h066;
        tick();
        wr_valid = 1'b0;
        read_at("ign_rd0", 0, 9'h055);
        read_at("ign_rd1", 1, 9'h066);

        // Full-depth load with pointer wrap.
        start(DEPTH);
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = DW'(i ^ 'h155);
            tick();
        end
        check("full_done", 32'(done), 32'd1);
        wr_data = 9'h000;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            read_at("full_rd", i, DW'(i ^ 'h155));

        // Reset after two of five words.
        start(5);
        wr_valid = 1'b1;
        wr_data  = 9'h011;
        tick();
        wr_data  = 9'h022;
        tick();
        reset   = 1'b1;
        wr_data = 9'h033;
        tick();
        reset    = 1'b0;
        wr_valid = 1'b0;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_wr_ready", 32'(wr_ready), 32'd0);
        read_at("mr_rd0", 0, 9'h011);
        read_at("mr_rd1", 1, 9'h022);
        read_at("mr_rd2", 2, 9'h157);
        read_at("mr_rd3", 3, 9'h156);
        read_at("mr_rd4", 4, 9'h151);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter IW, default 10: instruction address width; memory depth is 2**IW words.
REQ-002 Parameter DW, default 9: machine-code word width.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-high.
REQ-005 LoadStart  input  1  single-cycle request to begin a program load.
REQ-006 LoadCount  input  IW+1  number of words to load, sampled with LoadStart.
REQ-007 WrValid  input  1  WrData holds a valid program word.
REQ-008 WrData  input  DW  program word, written in ascending address order from 0.
REQ-009 WrReady  output  1  loader accepts a word this cycle.
REQ-010 InstAddress  input  IW  fetch address from the program counter.
REQ-011 InstOut  output  DW  instruction at InstAddress.
REQ-012 Busy  output  1  load in progress; the CPU shall stall while high.
REQ-013 Done  output  1  the most recent load completed.
REQ-014 Err  output  1  the most recent LoadStart was rejected (sticky).

Function
REQ-015 The block SHALL hold a 2**IW x DW instruction memory, written only through the load port.
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-017 IDLE/DONE + LoadStart with 1 <= LoadCount <= 2**IW: go to LOAD, write pointer := 0, accepted count := 0, Done := 0, Err := 0.
REQ-018 IDLE/DONE + LoadStart with LoadCount == 0: go to DONE, Done := 1, Err := 0, no memory write.
REQ-019 IDLE/DONE + LoadStart with LoadCount > 2**IW: stay in current state, Err := 1, Done := 0, no memory write.
REQ-020 WrReady SHALL be 1 exactly when the state is LOAD, driven from registered state only.
REQ-021 Each cycle with WrValid && WrReady SHALL write WrData to mem[pointer] at that edge, then increment the pointer and accepted count by 1.
REQ-022 The write of word LoadCount-1 SHALL move the FSM to DONE at the same edge; Done = 1 and WrReady = 0 on the next cycle.
REQ-023 WrValid while WrReady == 0 SHALL be ignored with no write and no pointer change; the producer holds WrData until accepted.
REQ-024 LoadStart during LOAD SHALL be ignored.
REQ-025 Busy SHALL equal (state == LOAD).
REQ-026 InstOut SHALL be combinational on InstAddress and equal mem[InstAddress] when Busy == 0.
REQ-027 InstOut SHALL be all zeros while Busy == 1.
REQ-028 A read in the same cycle as a write to the same address SHALL return the pre-write contents.
REQ-029 A load with LoadCount == 2**IW SHALL write every address; the pointer wraps to 0 after the final write, and no further write occurs.
REQ-030 A load shorter than a previous one SHALL leave addresses >= LoadCount unchanged.
REQ-031 Done SHALL stay 1 in DONE until the next accepted LoadStart or Reset.

Reset
REQ-032 Reset SHALL force state IDLE, pointer 0, accepted count 0, Done 0, Err 0, Busy 0, WrReady 0 at the next rising edge, including mid-load.
REQ-033 Reset SHALL NOT clear memory contents, and no write SHALL occur in a cycle where Reset is 1.
REQ-034 A load interrupted by Reset SHALL leave the words written before the reset edge in memory.

Verification
REQ-035 Basic load: LoadStart, LoadCount=3; words 0x0E0, 0x0B0, 0x091 with WrValid held high -> WrReady high 3 cycles, Done=1 on cycle 4; InstAddress 0/1/2 reads 0x0E0/0x0B0/0x091.
REQ-036 Backpressure and gaps: LoadCount=4 with WrValid toggling 1,0,1,0,1,1 -> exactly 4 writes to addresses 0..3 in order; WrValid pulses after Done cause no writes.
REQ-037 Rejection: LoadCount=1025 with IW=10 -> Err=1, state IDLE, memory unchanged. Then LoadCount=0 -> Done=1, Err=0, memory unchanged.
REQ-038 Full depth: LoadCount=1024 with WrData = address ^ 0x155 -> every address reads back correctly; pointer wraps with no extra write.
REQ-039 Mid-load reset: Reset asserted after 2 of 5 words -> next cycle Busy=0, Done=0, WrReady=0; addresses 0-1 hold new data and 2-4 hold old data.
REQ-040 Stall output: during LOAD, any InstAddress -> InstOut=0; after Done, InstOut matches the stored word.
